mult_pipe_mac: RTL
==================

MULT_PIPE_MAC -- requirements
Module: mult_pipe_mac

Interface
REQ-001 SHALL have parameter M, default 8, width of operand A.
REQ-002 SHALL have parameter N, default 8, width of operand B.
REQ-003 SHALL have parameter K, default 1, multiplier bits consumed per pipeline stage; N%K==0 required; S=N/K stages.
REQ-004 SHALL have parameter ACC_W, default M+N+8, accumulator width; ACC_W>=M+N required.
REQ-005 SHALL have port clk  input  1  rising-edge clock, only clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset (asserted at 0).
REQ-007 SHALL have port in_valid  input  1  input beat present.
REQ-008 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-009 SHALL have port in_a  input  M  operand A.
REQ-010 SHALL have port in_b  input  N  operand B.
REQ-011 SHALL have port in_signed  input  1  1: both operands two's complement; 0: both unsigned.
REQ-012 SHALL have port in_acc_en  input  1  add this product into accumulator.
REQ-013 SHALL have port in_acc_clr  input  1  zero accumulator before this beat's add.
REQ-014 SHALL have port out_valid  output  1  result beat present.
REQ-015 SHALL have port out_ready  input  1  downstream accepts result.
REQ-016 SHALL have port out_prod  output  M+N  exact product of the beat.
REQ-017 SHALL have port out_acc  output  ACC_W  accumulator value after this beat.
REQ-018 SHALL have port out_ovf  output  1  sticky accumulator overflow flag.

Function
REQ-019 SHALL accept a beat when in_valid && in_ready; in_signed, in_acc_en, in_acc_clr travel with it through every stage.
REQ-020 SHALL implement S shift-add stages each consuming K bits of B (LSB first), plus one output register; unstalled latency accept->out_valid = S+1 cycles.
REQ-021 SHALL sustain one beat per cycle when out_ready stays 1.
REQ-022 SHALL make out_prod the exact M+N-bit product: signed mode = two's complement product (no magnitude/negate post-step; most-negative operands correct); unsigned mode = zero-extended product.
REQ-023 SHALL use a global stall: advance = !out_valid || out_ready; in_ready = advance; all stages hold when advance=0.
REQ-024 SHALL hold out_prod, out_acc, out_ovf, out_valid stable while out_valid && !out_ready.
REQ-025 SHALL, with a valid-bit per stage, propagate bubbles; out_valid deasserts after a handshake with no valid beat behind it.
REQ-026 SHALL update the accumulator only when a beat enters the output register: base = in_acc_clr ? 0 : acc; acc <= in_acc_en ? base + ext(prod) : base; ext = sign-extend if signed else zero-extend.
REQ-027 SHALL present out_acc = the accumulator value after that update.
REQ-028 SHALL set out_ovf when the ACC_W-bit add overflows (signed: operand signs equal, result sign differs; unsigned: carry out); cleared only by a beat with in_acc_clr=1 (then reflects only that beat's add) or reset; accumulator wraps modulo 2^ACC_W.
REQ-029 SHALL ignore in_a/in_b/mode inputs when in_valid=0 or in_ready=0.

Reset
REQ-030 SHALL, on rst=0, asynchronously clear all stage valids, out_valid=0, out_prod=0, out_acc=0, accumulator=0, out_ovf=0; in-flight beats are discarded.
REQ-031 SHALL drive in_ready=1 during reset release's first cycle (pipeline empty).

Verification
REQ-032 SHALL pass: M=N=8,K=2, signed, A=0x80,B=0x80 -> out_prod=0x4000 exactly 5 cycles after accept.
REQ-033 SHALL pass: unsigned A=0xFF,B=0xFF -> 0xFE01; signed A=0xFF,B=0x05 -> 0xFFFB; back-to-back beats -> results in order, one per cycle.
REQ-034 SHALL pass: 6 beats streamed, out_ready=0 for 3 cycles once out_valid -> out_* held, in_ready=0, no beat lost/duplicated, order preserved.
REQ-035 SHALL pass: signed beats (3,4,clr=1,en=1),(5,-2,en=1),(7,7,en=0) -> out_acc 12, 2, 2; ACC_W=16 unsigned 0xFF*0xFF added twice -> out_acc=0xFC02, out_ovf=1 until next clr beat.
REQ-036 SHALL pass: rst=0 asserted mid-stream with 3 beats in flight -> outputs zero immediately, no stale beat appears after release.

Source files
------------

// File: rtl/mult_pipe_mac.sv
// Pipelined shift-add multiplier with a multiply-accumulate output stage.
// K multiplier bits per stage, global stall, sticky accumulator overflow.
module mult_pipe_mac #(
    parameter int M     = 8,
    parameter int N     = 8,
    parameter int K     = 1,
    parameter int ACC_W = M + N + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_signed,
    input  logic             in_acc_en,
    input  logic             in_acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M+N-1:0]   out_prod,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int S = N / K;
    localparam int P = M + N;

    logic advance;

    // Whole pipeline moves together; the output register gates everything.
    logic out_v_q;
    assign advance   = !out_v_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_v_q;

    for (genvar i = 0; i < S; i++) begin : g_stg
        // Multiplier bits still unconsumed when a beat enters this stage.
        localparam int RB = N - K * i;

        logic          v_s;
        logic          sg_s;
        logic          en_s;
        logic          clr_s;
        logic [P-1:0]  a_s;
        logic [P-1:0]  ps_s;
        logic [RB-1:0] b_s;

        logic          v_q;
        logic          sg_q;
        logic          en_q;
        logic          clr_q;
        logic [P-1:0]  ps_q;
        logic [P-1:0]  ps_d;

        if (i == 0) begin : g_src
            assign v_s   = in_valid;
            assign sg_s  = in_signed;
            assign en_s  = in_acc_en;
            assign clr_s = in_acc_clr;
            // Operand A widened once; sign-extended only in signed mode.
            assign a_s   = {{N{in_a[M-1] & in_signed}}, in_a};
            assign b_s   = in_b;
            assign ps_s  = '0;
        end else begin : g_src
            assign v_s   = g_stg[i-1].v_q;
            assign sg_s  = g_stg[i-1].sg_q;
            assign en_s  = g_stg[i-1].en_q;
            assign clr_s = g_stg[i-1].clr_q;
            assign a_s   = g_stg[i-1].g_cy.a_q;
            assign b_s   = g_stg[i-1].g_cy.b_q;
            assign ps_s  = g_stg[i-1].ps_q;
        end

        // Add this stage's K partial products; the B sign bit weighs negative.
        always_comb begin
            ps_d = ps_s;
            for (int j = 0; j < K; j++) begin
                if (b_s[j]) begin
                    if (sg_s && (i * K + j == N - 1)) begin
                        ps_d = ps_d - (a_s << (i * K + j));
                    end else begin
                        ps_d = ps_d + (a_s << (i * K + j));
                    end
                end
            end
        end

        // Stage register: valid bit, beat flags and running partial sum.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q   <= 1'b0;
                sg_q  <= 1'b0;
                en_q  <= 1'b0;
                clr_q <= 1'b0;
                ps_q  <= '0;
            end else if (advance) begin
                v_q   <= v_s;
                sg_q  <= sg_s;
                en_q  <= en_s;
                clr_q <= clr_s;
                ps_q  <= ps_d;
            end
        end

        if (i < S - 1) begin : g_cy
            logic [P-1:0]    a_q;
            logic [RB-K-1:0] b_q;

            // Operands carried forward; consumed B bits are dropped.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_s;
                    b_q <= b_s[RB-1:K];
                end
            end
        end
    end

    logic             last_v;
    logic             last_sg;
    logic             last_en;
    logic             last_clr;
    logic [P-1:0]     last_ps;

    assign last_v   = g_stg[S-1].v_q;
    assign last_sg  = g_stg[S-1].sg_q;
    assign last_en  = g_stg[S-1].en_q;
    assign last_clr = g_stg[S-1].clr_q;
    assign last_ps  = g_stg[S-1].ps_q;

    logic [P-1:0]     prod_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;
    logic             ovf_add;

    // Accumulate the finished product; overflow is sticky until a clear beat.
    always_comb begin
        ext     = last_sg ? ACC_W'($signed(last_ps)) : ACC_W'(last_ps);
        base    = last_clr ? '0 : acc_q;
        sum     = {1'b0, base} + {1'b0, ext};
        ovf_add = 1'b0;
        if (last_sg) begin
            ovf_add = (base[ACC_W-1] == ext[ACC_W-1])
                   && (sum[ACC_W-1] != base[ACC_W-1]);
        end else begin
            ovf_add = sum[ACC_W];
        end
        acc_d = last_en ? sum[ACC_W-1:0] : base;
        ovf_d = (last_clr ? 1'b0 : ovf_q) | (last_en & ovf_add);
    end

    // Output register; data and accumulator only move on a real beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_v_q <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (advance) begin
            out_v_q <= last_v;
            if (last_v) begin
                prod_q <= last_ps;
                acc_q  <= acc_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_prod = prod_q;
    assign out_acc  = acc_q;
    assign out_ovf  = ovf_q;

endmodule
